// File: rtl/dc.sv
// dc: data-access stage between EX and MEM.
// Issues one data SRAM request per load/store and stalls until it returns.
module dc #(
  parameter int EX_TO_DC_WD  = 174,
  parameter int DC_TO_MEM_WD = 142,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_DC_WD-1:0]  ex_to_dc_bus,
  output logic [DC_TO_MEM_WD-1:0] dc_to_mem_bus,
  output logic [31:0]             dc_rdata,
  output logic                    stallreq_for_dc,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  input  logic                    data_sram_addr_ok,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata
);

  localparam int  EN_BIT   = 75;
  localparam int  WEN_LSB  = 71;
  localparam int  ADDR_LSB = 32;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_CANCEL
  } state_t;

  logic [EX_TO_DC_WD-1:0] r_bus;
  state_t                 r_state;
  logic [31:0]            r_rdata_hold;

  logic        w_mem_op;
  logic [3:0]  w_wen;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_own_stop;
  logic        w_mem_stop;
  logic        w_issue;
  logic        w_en;
  logic        w_resp;
  logic        w_unused_stall;

  assign w_mem_op   = r_bus[EN_BIT];
  assign w_wen      = r_bus[WEN_LSB +: 4];
  assign w_addr     = r_bus[ADDR_LSB +: 32];
  assign w_wdata    = r_bus[31:0];
  assign w_own_stop = stall[4];
  assign w_mem_stop = stall[5];
  assign w_unused_stall = ^stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus <= '0;
    end else if (flush) begin
      r_bus <= '0;
    end else if (w_own_stop == STOP && w_mem_stop == NO_STOP) begin
      r_bus <= '0;
    end else if (w_own_stop == NO_STOP) begin
      r_bus <= ex_to_dc_bus;
    end
  end

  // A flush in IDLE suppresses the request before the SRAM can see it.
  assign w_issue = (r_state == S_IDLE) & w_mem_op & ~flush;
  assign w_en    = w_issue | (r_state == S_REQ);
  assign w_resp  = (r_state == S_WAIT) & data_sram_data_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rdata_hold <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_op && !flush)
            r_state <= data_sram_addr_ok ? S_WAIT : S_REQ;
        end
        S_REQ: begin
          if (flush)
            r_state <= data_sram_addr_ok ? S_CANCEL : S_IDLE;
          else if (data_sram_addr_ok)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (data_sram_data_ok) begin
            r_rdata_hold <= data_sram_rdata;
            if (flush || w_mem_stop == NO_STOP)
              r_state <= S_IDLE;
            else
              r_state <= S_DONE;
          end else if (flush) begin
            r_state <= S_CANCEL;
          end
        end
        S_DONE: begin
          if (flush || w_mem_stop == NO_STOP)
            r_state <= S_IDLE;
        end
        S_CANCEL: begin
          if (data_sram_data_ok)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stallreq_for_dc = w_mem_op & ~(w_resp | (r_state == S_DONE));
  assign dc_rdata        = w_resp ? data_sram_rdata : r_rdata_hold;
  assign dc_to_mem_bus   = r_bus[EX_TO_DC_WD-1:32];

  assign data_sram_en    = w_en;
  assign data_sram_wen   = w_en ? w_wen : 4'b0;
  assign data_sram_addr  = w_en ? w_addr : 32'b0;
  assign data_sram_wdata = w_en ? w_wdata : 32'b0;

  a_data_ok_expected: assert property (
    @(posedge clk) disable iff (rst)
    data_sram_data_ok |-> (r_state == S_WAIT || r_state == S_CANCEL)
  );

endmodule

// File: tb/tb_dc.sv
// tb_dc: random and directed stimulus for dc against a transaction-level
// model of the stage slot, a latency-programmable SRAM and MEM's latch.
module tb_dc;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [5:0]    stall;
  logic [173:0]  ex_bus;
  logic [141:0]  dc_to_mem_bus;
  logic [31:0]   dc_rdata;
  logic          stallreq;
  logic          en;
  logic [3:0]    wen;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [31:0]   rdata;

  logic r_mem_stall;
  logic r_ex_stall;
  logic w5;

  int       a_lat;
  int       d_lat;
  int       acnt;
  int       dcnt;
  bit       pend;
  logic [31:0] pdata;
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign w5    = stallreq | r_mem_stall;
  assign stall = {w5, w5 | r_ex_stall, {4{w5 | r_ex_stall}}};

  dc dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall             (stall),
    .ex_to_dc_bus      (ex_bus),
    .dc_to_mem_bus     (dc_to_mem_bus),
    .dc_rdata          (dc_rdata),
    .stallreq_for_dc   (stallreq),
    .data_sram_en      (en),
    .data_sram_wen     (wen),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [173:0] mk(input logic men, input logic [3:0] mwen,
                                      input logic we, input logic [31:0] a,
                                      input logic [31:0] sd);
    logic [65:0] hilo;
    hilo = {2'($urandom), $urandom, $urandom};
    return {hilo, $urandom, men, mwen, 1'($urandom), we, 5'($urandom), a, sd};
  endfunction

  task automatic chk(input string nm, input logic [173:0] act,
                     input logic [173:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // SRAM: addr_ok after a_lat cycles of en, data_ok d_lat cycles later.
  assign addr_ok = en && !pend && (acnt >= a_lat);
  assign data_ok = pend && (dcnt == 0);
  assign rdata   = data_ok ? pdata : 32'hBAD0BAD0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      acnt <= 0;
      dcnt <= 0;
      pdata <= '0;
    end else begin
      if (en && !addr_ok) acnt <= acnt + 1;
      else acnt <= 0;
      if (en && addr_ok) begin
        pend  <= 1'b1;
        dcnt  <= d_lat - 1;
        pdata <= memval(addr);
      end else if (data_ok) begin
        pend <= 1'b0;
      end else if (pend && dcnt > 0) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  logic [173:0] slot;
  int           req_cnt;
  int           stall_run;
  bit           p_hold;
  logic [67:0]  p_req;
  logic [31:0]  last_mem_rdata;
  logic [141:0] last_mem_bus;
  logic [3:0]   last_req_wen;

  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      slot      = '0;
      req_cnt   = 0;
      stall_run = 0;
      p_hold    = 0;
    end else begin
      if (p_hold)
        chk("req_stable", {en, addr, wen, wdata}, {1'b1, p_req});
      if (en) begin
        chk("req_fields", {1'b1, addr, wen, wdata},
            {slot[75], slot[63:32], slot[74:71], slot[31:0]});
        chk("one_outstanding", pend, 0);
      end
      if (en && addr_ok) begin
        req_cnt++;
        last_req_wen = wen;
      end
      p_hold = en && !addr_ok && !flush;
      p_req  = {addr, wen, wdata};
      if (!slot[75])
        chk("no_stall_non_mem", stallreq, 0);
      if (!stall[5] && !flush) begin
        chk("mem_bus", dc_to_mem_bus, slot[173:32]);
        if (slot[75]) begin
          chk("req_count", req_cnt, 1);
          req_cnt        = 0;
          last_mem_bus   = dc_to_mem_bus;
          last_mem_rdata = dc_rdata;
          if (slot[74:71] == 4'b0)
            chk("load_data", dc_rdata, memval(slot[63:32]));
        end
      end
      if (flush) req_cnt = 0;
      stall_run = stallreq ? stall_run + 1 : 0;
      if (stall_run > 60) begin
        checks++;
        errors++;
        $display("FAIL watchdog: stallreq high %0d cycles, required < 60",
                 stall_run);
        stall_run = 0;
      end
      if (flush) slot = '0;
      else if (stall[4] && !stall[5]) slot = '0;
      else if (!stall[4]) slot = ex_bus;
    end
  end

  task automatic run_single(input logic [173:0] op, output int n);
    @(negedge clk);
    ex_bus = op;
    @(negedge clk);
    ex_bus = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (!stallreq) break;
      n++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [3:0] rand_wen();
    case ($urandom_range(0, 6))
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b1000;
      4: return 4'b0011;
      5: return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    flush = 1'b0;
    ex_bus = '0;
    r_mem_stall = 1'b0;
    r_ex_stall = 1'b0;
    a_lat = 0;
    d_lat = 1;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_outputs", {en, wen, addr, wdata, stallreq, dc_rdata, dc_to_mem_bus},
        '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("idle_outputs", {en, stallreq, dc_rdata, dc_to_mem_bus}, '0);

    mem[32'h100] = 32'hDEADBEEF;
    run_single(mk(1'b1, 4'b0, 1'b1, 32'h100, $urandom), n);
    chk("t1_stall_cycles", n, 1);
    chk("t1_mem_rdata", last_mem_rdata, 32'hDEADBEEF);

    mem[32'h104] = 32'hCAFEF00D;
    a_lat = 3;
    d_lat = 2;
    run_single(mk(1'b1, 4'b0, 1'b1, 32'h104, $urandom), n);
    chk("t2_stall_cycles", n, 5);
    chk("t2_mem_rdata", last_mem_rdata, 32'hCAFEF00D);

    a_lat = 0;
    d_lat = 1;
    run_single(mk(1'b1, 4'b0100, 1'b0, 32'h202, 32'h00AA0000), n);
    chk("t3_stall_cycles", n, 1);
    chk("t3_req_wen", last_req_wen, 4'b0100);
    chk("t3_mem_wen", last_mem_bus[42:39], 4'b0100);

    mem[32'h300] = 32'h33334444;
    @(negedge clk);
    ex_bus = mk(1'b1, 4'b0, 1'b1, 32'h300, $urandom);
    @(negedge clk);
    ex_bus = '0;
    r_mem_stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("t4_done_stallreq", stallreq, 0);
    chk("t4_done_en", en, 0);
    chk("t4_done_rdata", dc_rdata, 32'h33334444);
    @(negedge clk);
    #3;
    chk("t4_hold_rdata", dc_rdata, 32'h33334444);
    @(negedge clk);
    r_mem_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_mem_rdata", last_mem_rdata, 32'h33334444);

    mem[32'h400] = 32'h11111111;
    mem[32'h500] = 32'h22222222;
    d_lat = 4;
    @(negedge clk);
    ex_bus = mk(1'b1, 4'b0, 1'b1, 32'h400, $urandom);
    @(negedge clk);
    ex_bus = '0;
    @(negedge clk);
    flush = 1'b1;
    ex_bus = mk(1'b1, 4'b0, 1'b1, 32'h500, $urandom);
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    ex_bus = '0;
    #3;
    chk("t5_cancel_no_en", en, 0);
    chk("t5_cancel_stallreq", stallreq, 1);
    for (int i = 0; i < 40; i++) begin
      if (!stallreq) break;
      @(negedge clk);
      #3;
    end
    repeat (2) @(negedge clk);
    chk("t5_mem_rdata", last_mem_rdata, 32'h22222222);

    d_lat = 5;
    @(negedge clk);
    ex_bus = mk(1'b1, 4'b0, 1'b1, 32'h600, $urandom);
    @(negedge clk);
    ex_bus = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_reset", {en, wen, addr, wdata, stallreq, dc_rdata, dc_to_mem_bus},
        '0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("t6_after_reset", {en, stallreq}, 0);

    for (int c = 0; c < 800; c++) begin
      int kind;
      @(negedge clk);
      flush       = ($urandom_range(0, 99) < 4);
      r_ex_stall  = ($urandom_range(0, 99) < 10);
      r_mem_stall = ($urandom_range(0, 99) < 15);
      a_lat = $urandom_range(0, 2);
      d_lat = $urandom_range(1, 3);
      kind  = $urandom_range(0, 3);
      case (kind)
        1: ex_bus = mk(1'b1, 4'b0, 1'b1, $urandom, $urandom);
        2: ex_bus = mk(1'b1, rand_wen(), 1'b0, $urandom, $urandom);
        default: ex_bus = mk(1'b0, 4'b0, 1'b1, $urandom, $urandom);
      endcase
    end
    @(negedge clk);
    flush = 1'b0;
    r_ex_stall = 1'b0;
    r_mem_stall = 1'b0;
    ex_bus = '0;
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
